// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline-side signals exchanged with the sequencing controller.
// The pipeline (master) drives stall requests and exception strobes; the
// controller (slave) returns the stall vector, flush pulse, redirect PC,
// watchdog flag and performance counters.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    // Requests from the pipeline stages
    logic             stallreq_from_id;
    logic             stallreq_from_ex;
    logic             stallreq_from_mem;
    // Exception commit from MEM
    logic             except_valid_i;
    logic [3:0]       except_type_i;
    logic [31:0]      cp0_epc_i;
    // Controller responses
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] flush_count_o;

    modport master (
        output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output except_valid_i, except_type_i, cp0_epc_i,
        input  stall, flush, new_pc, timeout_o, stall_cycles_o, flush_count_o
    );

    modport slave (
        input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  except_valid_i, except_type_i, cp0_epc_i,
        output stall, flush, new_pc, timeout_o, stall_cycles_o, flush_count_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Merges ID/EX/MEM stall requests into a per-register stall vector,
// sequences exception flushes (freeze -> flush + redirect -> run), runs a
// stall watchdog and keeps saturating stall/flush performance counters.
//
// Handshake semantics: there is no back-pressure on this block. A stall
// request is a level that takes effect in the same cycle (combinational
// path to stall). except_valid_i is a strobe sampled only in RUN at the
// rising edge; in EXC and FLUSH it is ignored, so a source that holds it
// high simply retriggers on the first RUN cycle. flush is a one-cycle
// pulse and new_pc is meaningful while flush is high (it then holds until
// the next exception is sequenced).
//
// The interface instance must be built with the same CNT_W as this module.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          MAX_STALL  = 64,
    parameter int          CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus,
    output logic [1:0]   state_dbg
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_EXC   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [3:0] EXC_ERET = 4'hE;

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [3:0]       exc_type_q;
    logic [31:0]      exc_epc_q;
    logic [31:0]      new_pc_q;
    logic [CNT_W-1:0] wd_cnt_q;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [5:0]       req_stall;
    logic [5:0]       stall_c;
    logic             exc_take;

    // An exception is only accepted while the pipe is running normally
    assign exc_take = (state_q == S_RUN) && bus.except_valid_i;

    // Merge stage requests: the deepest requesting stage freezes everything upstream
    always_comb begin
        req_stall = STALL_NONE;
        if (bus.stallreq_from_mem) begin
            req_stall = STALL_MEM;
        end else if (bus.stallreq_from_ex) begin
            req_stall = STALL_EX;
        end else if (bus.stallreq_from_id) begin
            req_stall = STALL_ID;
        end
    end

    // Stall vector per state; the EXC freeze bubbles MEM/WB so the faulting op never retires
    always_comb begin
        stall_c = STALL_NONE;
        if (!rst) begin
            case (state_q)
                S_RUN:   stall_c = req_stall;
                S_EXC:   stall_c = STALL_MEM;
                default: stall_c = STALL_NONE;
            endcase
        end
    end

    // Exception sequencing: RUN -> EXC (one freeze cycle) -> FLUSH (one pulse) -> RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (bus.except_valid_i) state_d = S_EXC;
            S_EXC:   state_d = S_FLUSH;
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture exception type and EPC at the moment the exception is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_type_q <= 4'h0;
            exc_epc_q  <= 32'h0;
        end else if (exc_take) begin
            exc_type_q <= bus.except_type_i;
            exc_epc_q  <= bus.cp0_epc_i;
        end
    end

    // Redirect target computed at the end of EXC so it is valid during FLUSH, then held
    always_ff @(posedge clk) begin
        if (rst) begin
            new_pc_q <= 32'h0;
        end else if (state_q == S_EXC) begin
            new_pc_q <= (exc_type_q == EXC_ERET) ? exc_epc_q : EXC_VECTOR;
        end
    end

    // Watchdog: counts consecutive stalled RUN cycles, sets a sticky flag on reaching the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (stall_c == STALL_NONE) begin
            wd_cnt_q <= '0;
        end else if (state_q == S_RUN && wd_cnt_q != WD_MAX) begin
            wd_cnt_q <= wd_cnt_q + CNT_ONE;
            if (wd_cnt_q + CNT_ONE == WD_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_c[0] && stall_cnt_q != CNT_SAT) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    // Saturating count of flushes, stepped on the EXC -> FLUSH transition
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else if (state_q == S_EXC && flush_cnt_q != CNT_SAT) begin
            flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign bus.stall          = stall_c;
    assign bus.flush          = (state_q == S_FLUSH);
    assign bus.new_pc         = new_pc_q;
    assign bus.timeout_o      = timeout_q;
    assign bus.stall_cycles_o = stall_cnt_q;
    assign bus.flush_count_o  = flush_cnt_q;
    assign state_dbg          = state_q;

endmodule
